load_store_unit: RTL and testbench

- Memory stage directly downstream of the ALU: consumes ALUResult as the effective address and the rs2 value as store data.
- Runs one data-memory transaction over a req/ack handshake.
- Generates byte enables and lane-replicated store data; aligns and sign/zero-extends load data.
- Flags misaligned or illegal accesses without touching the bus.

---
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store memory stage: one req/ack data-memory transaction per Start, with
// byte-lane steering and load extension. Define LSU_TIMEOUT_EN to abort stalled requests.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Done,
  output logic        Busy,
  output logic        Err,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemBE,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_nx;
  logic        we_p1;
  logic [2:0]  f3_p1;
  logic [31:0] addr_p1;
  logic [31:0] wdata_p1;
  logic [3:0]  be_p1;
  logic        err_p1;
  logic [31:0] rdata_p2;
  logic        launch;
  logic        illegal;
  logic        timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  function automatic logic access_illegal(input logic we, input logic [2:0] f3,
                                          input logic [1:0] a);
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return a != 2'b00;
      3'b100:  return we;
      3'b101:  return we | a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Right-justify the addressed lane, then extend by width and signedness.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rd);
    logic signed [31:0] s;
    s = $signed(rd >> {a, 3'b000});
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return s;
    endcase
  endfunction

  assign launch  = (state == IDLE) && Start;
  assign illegal = access_illegal(MemWrite, Funct3, ALUResult[1:0]);

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_p1;

  // Ack in the final allowed cycle takes priority over the abort.
  assign timeout = (state == REQ) && !MemAck && (cnt_p1 == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset || state != REQ) cnt_p1 <= '0;
    else if (!MemAck)          cnt_p1 <= cnt_p1 + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      err_p1 <= 1'b0;
    end else begin
      state <= state_nx;
      if (launch)       err_p1 <= illegal;
      else if (timeout) err_p1 <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Start) state_nx = illegal ? DONE : REQ;
      REQ:     if (MemAck || timeout) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request stage: latch the access; result stage: capture aligned load data.
  always_ff @(posedge clk) begin
    if (launch) begin
      we_p1    <= MemWrite;
      f3_p1    <= Funct3;
      addr_p1  <= ALUResult;
      be_p1    <= lane_be(Funct3, ALUResult[1:0]);
      wdata_p1 <= lane_wdata(Funct3, WriteData);
      rdata_p2 <= '0;
    end else if (state == REQ && MemAck && !we_p1) begin
      rdata_p2 <= load_extend(f3_p1, addr_p1[1:0], MemRData);
    end
  end

  always_comb begin
    MemReq   = (state == REQ);
    MemWe    = MemReq & we_p1;
    MemAddr  = MemReq ? {addr_p1[31:2], 2'b00} : 32'd0;
    MemBE    = MemReq ? be_p1 : 4'd0;
    MemWData = MemWe ? wdata_p1 : 32'd0;
    Done     = (state == DONE);
    Busy     = (state != IDLE);
    Err      = Done & err_p1;
    ReadData = Done ? rdata_p2 : 32'd0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand sequences and
// randomized accesses checked against an arithmetic reference model.
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
  localparam int STALL = 3;
`else
  localparam int STALL = 5;
`endif

  logic        clk = 1'b0;
  logic        reset, Start, MemWrite, MemAck;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData, MemRData;
  logic [31:0] ReadData, MemAddr, MemWData;
  logic        Done, Busy, Err, MemReq, MemWe;
  logic [3:0]  MemBE;

  int tests = 0;
  int fails = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MemWrite(MemWrite), .Funct3(Funct3),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData), .Done(Done),
    .Busy(Busy), .Err(Err), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemBE(MemBE), .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          wait_n;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: sizes in bytes, offsets and masks by plain arithmetic.
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic m_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b011 || f3[2:1] == 2'b11) return 1'b1;
    if (we && f3[2]) return 1'b1;
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = m_size(f3);
    int v  = ((1 << sz) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int sz = m_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rd);
    int          bits = 8 * m_size(f3);
    logic [31:0] mask;
    logic [31:0] v;
    mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    v    = (rd >> (8 * (a % 4))) & mask;
    if (!f3[2] && bits < 32 && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    MemWrite = v.we; Funct3 = v.f3; ALUResult = v.addr; WriteData = v.wd; Start = 1'b1;
    step();
    Start = 1'b0;
    if (v.exp_err) begin
      check({tag, " err Done"}, Done, 1'b1);
      check({tag, " err Err"}, Err, 1'b1);
      check({tag, " err MemReq"}, MemReq, 1'b0);
      check({tag, " err ReadData"}, ReadData, 32'd0);
      step();
      check({tag, " err Done low"}, Done, 1'b0);
      return;
    end
    for (int i = 0; i <= v.wait_n; i++) begin
      check({tag, " MemReq"}, MemReq, 1'b1);
      check({tag, " MemAddr"}, MemAddr, {v.addr[31:2], 2'b00});
      check({tag, " MemBE"}, MemBE, v.exp_be);
      check({tag, " MemWe"}, MemWe, v.we);
      if (v.we) check({tag, " MemWData"}, MemWData, v.exp_wdata);
      check({tag, " Done early"}, Done, 1'b0);
      // A stray Start while busy must not disturb the latched access.
      Start     = (i < v.wait_n);
      ALUResult = $urandom;
      Funct3    = 3'(i);
      MemAck    = (i == v.wait_n);
      MemRData  = (i == v.wait_n) ? v.rd : $urandom;
      step();
    end
    MemAck = 1'b0; Start = 1'b0;
    check({tag, " Done"}, Done, 1'b1);
    check({tag, " Err"}, Err, 1'b0);
    check({tag, " ReadData"}, ReadData, v.exp_rdata);
    check({tag, " MemReq after ack"}, MemReq, 1'b0);
    step();
    check({tag, " Done one cycle"}, Done, 1'b0);
    check({tag, " Busy idle"}, Busy, 1'b0);
  endtask

  vec_t tbl[$];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input int wn,
                              input logic [3:0] be, input logic [31:0] wdat,
                              input logic [31:0] rdat, input logic err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd; v.wait_n = wn;
    v.exp_be = be; v.exp_wdata = wdat; v.exp_rdata = rdat; v.exp_err = err;
    return v;
  endfunction

  initial begin
    reset = 1'b1; Start = 1'b0; MemWrite = 1'b0; Funct3 = 3'b0; ALUResult = '0;
    WriteData = '0; MemRData = '0; MemAck = 1'b0;
    step(); step();
    check("reset Busy", Busy, 1'b0);
    check("reset Done", Done, 1'b0);
    check("reset MemReq", MemReq, 1'b0);
    check("reset MemBE", MemBE, 4'd0);
    check("reset ReadData", ReadData, 32'd0);
    reset = 1'b0;
    step();

    tbl.push_back(mk(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 1, 4'b1111, 0, 32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 3'b000, 32'h203, 0, 32'h80FF7F01, 0, 4'b1000, 0, 32'hFFFFFF80, 0));
    tbl.push_back(mk(0, 3'b100, 32'h201, 0, 32'h80FF7F01, 2, 4'b0010, 0, 32'h0000007F, 0));
    tbl.push_back(mk(0, 3'b001, 32'h202, 0, 32'h80FF7F01, 1, 4'b1100, 0, 32'hFFFF80FF, 0));
    tbl.push_back(mk(0, 3'b101, 32'h200, 0, 32'h80FF7F01, 0, 4'b0011, 0, 32'h00007F01, 0));
    tbl.push_back(mk(1, 3'b000, 32'h302, 32'h12345678, 0, 1, 4'b0100, 32'h78787878, 0, 0));
    tbl.push_back(mk(1, 3'b001, 32'h302, 32'h12345678, 0, 0, 4'b1100, 32'h56785678, 0, 0));
    tbl.push_back(mk(1, 3'b010, 32'h304, 32'h12345678, 0, STALL, 4'b1111, 32'h12345678, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h101, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 3'b001, 32'h103, 32'h12345678, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 3'b100, 32'h100, 32'h12345678, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 3'b110, 32'h100, 0, 0, 0, 0, 0, 0, 1));
    foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

    // MemAck while idle is ignored.
    MemAck = 1'b1;
    step();
    check("stray ack Busy", Busy, 1'b0);
    check("stray ack Done", Done, 1'b0);
    MemAck = 1'b0;

    // Reset while a request is outstanding abandons it without Done.
    MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h400; Start = 1'b1;
    step();
    Start = 1'b0;
    check("pre-reset MemReq", MemReq, 1'b1);
    reset = 1'b1;
    step();
    check("reset in REQ MemReq", MemReq, 1'b0);
    check("reset in REQ Busy", Busy, 1'b0);
    reset = 1'b0;
    step();
    check("reset in REQ no Done", Done, 1'b0);

`ifdef LSU_TIMEOUT_EN
    MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h500; Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("timeout MemReq", MemReq, 1'b1);
      step();
    end
    check("timeout MemReq drop", MemReq, 1'b0);
    check("timeout Done", Done, 1'b1);
    check("timeout Err", Err, 1'b1);
    check("timeout ReadData", ReadData, 32'd0);
    step();
`else
    MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h500; Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("long stall MemReq", MemReq, 1'b1);
    check("long stall Done", Done, 1'b0);
    MemAck = 1'b1; MemRData = 32'hCAFEF00D;
    step();
    MemAck = 1'b0;
    check("long stall ReadData", ReadData, 32'hCAFEF00D);
    step();
`endif

    for (int n = 0; n < 200; n++) begin
      vec_t v;
      v.we   = $urandom_range(0, 1);
      v.f3   = 3'($urandom_range(0, 7));
      v.addr = $urandom;
      v.wd   = $urandom;
      v.rd   = $urandom;
      v.wait_n    = $urandom_range(0, 3);
      v.exp_err   = m_illegal(v.we, v.f3, v.addr);
      v.exp_be    = v.exp_err ? 4'd0 : m_be(v.f3, v.addr);
      v.exp_wdata = v.exp_err ? 32'd0 : m_wdata(v.f3, v.wd);
      v.exp_rdata = (v.exp_err || v.we) ? 32'd0 : m_rdata(v.f3, v.addr, v.rd);
      run_txn(v, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
